cregister_write_ctrl: RTL

//  Write-side controller placed directly upstream of the Impulse C register

---
 rtl/cregister_write_ctrl_if.sv | 24 ++
 rtl/cregister_write_ctrl.sv | 108 ++++++++++
 2 files changed

// File: rtl/cregister_write_ctrl_if.sv
// Producer-side write handshake plus register-stage update outputs for cregister_write_ctrl.
// master = producer/observer, slave = controller.
interface cregister_write_ctrl_if #(
  parameter int datawidth = 8,
  parameter int cntwidth  = 8
);
  logic                 wr_valid;
  logic                 wr_ready;
  logic [datawidth-1:0] wr_data;
  logic                 reg_en;
  logic [datawidth-1:0] reg_data;
  logic                 busy;
  logic [cntwidth-1:0]  upd_count;

  modport master (
    output wr_valid, wr_data,
    input  wr_ready, reg_en, reg_data, busy, upd_count
  );

  modport slave (
    input  wr_valid, wr_data,
    output wr_ready, reg_en, reg_data, busy, upd_count
  );
endinterface

// File: rtl/cregister_write_ctrl.sv
// Write-side controller for the register stage: 2-entry FIFO feeding single-cycle
// reg_en pulses spaced at least min_gap cycles apart.
module cregister_write_ctrl #(
  parameter int datawidth = 8,
  parameter int min_gap   = 4,
  parameter int coalesce  = 0,
  parameter int cntwidth  = 8
) (
  input logic                   clk,
  input logic                   reset_n,
  cregister_write_ctrl_if.slave bus
);

  localparam int GW = $clog2(min_gap + 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'((min_gap > 1) ? (min_gap - 2) : 0);

  typedef enum logic {IDLE, GAP} state_t;

  state_t               state, state_next;
  logic [GW-1:0]        gap_cnt, gap_next;
  logic [datawidth-1:0] entry0, entry1;
  logic [1:0]           occ;
  logic                 ready, push, pop;
  logic                 reg_en_q;
  logic [datawidth-1:0] reg_data_q;
  logic [cntwidth-1:0]  upd_q;

  // Readiness uses registered occupancy only, so a full FIFO refuses even while popping.
  assign ready = (occ != 2'd2) || (coalesce != 0);
  assign push  = bus.wr_valid & ready;

  assign bus.wr_ready  = ready;
  assign bus.reg_en    = reg_en_q;
  assign bus.reg_data  = reg_data_q;
  assign bus.upd_count = upd_q;
  assign bus.busy      = (occ != 2'd0) || (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      gap_cnt <= '0;
    end else begin
      state   <= state_next;
      gap_cnt <= gap_next;
    end
  end

  // GAP spans min_gap-1 cycles including the pulse cycle, so the next pop lands min_gap edges later.
  always_comb begin
    state_next = state;
    gap_next   = gap_cnt;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (occ != 2'd0) begin
          pop = 1'b1;
          if (min_gap > 1) begin
            state_next = GAP;
            gap_next   = GAP_LOAD;
          end
        end
      end
      GAP: begin
        if (gap_cnt == '0) state_next = IDLE;
        else               gap_next   = gap_cnt - GW'(1);
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      entry0     <= '0;
      entry1     <= '0;
      occ        <= '0;
      reg_en_q   <= 1'b0;
      reg_data_q <= '0;
      upd_q      <= '0;
    end else begin
      reg_en_q <= pop;
      if (pop) begin
        reg_data_q <= entry0;
        upd_q      <= upd_q + cntwidth'(1);
      end
      case ({pop, push})
        2'b10: begin
          entry0 <= entry1;
          occ    <= occ - 2'd1;
        end
        2'b01: begin
          if (occ == 2'd0) entry0 <= bus.wr_data;
          else             entry1 <= bus.wr_data;
          if (occ != 2'd2) occ <= occ + 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            entry0 <= bus.wr_data;
          end else begin
            entry0 <= entry1;
            entry1 <= bus.wr_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
